// File: rtl/tsplit_pkg.sv
// Shared constants, FSM state type and piece-length sanitiser for the word splitter.
package tsplit_pkg;

    localparam int NLANES = 8;
    localparam int LW     = 4;
    localparam int DW     = 8 * NLANES;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } tsplit_state_e;

    // Out-of-range requests (0 or wider than a word) mean one whole-word piece.
    function automatic logic [LW-1:0] sanitise_len(input logic [LW-1:0] cfg);
        if (cfg == '0 || int'(cfg) > NLANES)
            return LW'(NLANES);
        return cfg;
    endfunction

endpackage

// File: rtl/tsplit_be_gen.sv
// Lane-mask generator: contiguous run of len lanes starting at off, plus last-piece flag.
module tsplit_be_gen
    import tsplit_pkg::*;
(
    input  logic [LW-1:0]     off,
    input  logic [LW-1:0]     len,
    output logic [NLANES-1:0] mask,
    output logic              last
);

    localparam logic [LW:0] LANES_W = (LW+1)'(NLANES);

    logic [LW:0] end_pos;

    // end_pos carries one extra bit so off+len never wraps.
    assign end_pos = {1'b0, off} + {1'b0, len};
    assign last    = (end_pos >= LANES_W);

    always_comb begin
        mask = '0;
        for (int i = 0; i < NLANES; i++)
            mask[i] = ((LW+1)'(i) >= {1'b0, off}) && ((LW+1)'(i) < end_pos);
    end

endmodule

// File: rtl/tsplit.sv
// Word splitter: pops 64-bit words from a show-ahead packet FIFO and writes lane-aligned,
// byte-enabled pieces into a piece FIFO.
module tsplit
    import tsplit_pkg::*;
(
    input  logic              clk,
    input  logic              reset_l,
    input  logic [LW-1:0]     cfg_piece_len,
    input  logic [DW-1:0]     pkt_fifo_rd_data,
    input  logic              pkt_fifo_ne,
    output logic              pkt_fifo_re,
    output logic [DW-1:0]     out_fifo_wr_data,
    output logic [NLANES-1:0] out_fifo_wr_be,
    output logic              out_fifo_we,
    input  logic              out_fifo_full,
    output logic [31:0]       piece_cnt
);

    // Handshake: a word is taken when pkt_fifo_ne is seen high in IDLE; pkt_fifo_re then
    // pulses for one cycle to pop it. A piece is offered only while out_fifo_full is low;
    // because out_fifo_we is registered, full must rise with at least one free entry left.

    tsplit_state_e     state, state_d;
    logic [DW-1:0]     hold;
    logic [LW-1:0]     off;
    logic [LW-1:0]     len;
    logic [NLANES-1:0] mask;
    logic              last;
    logic              capture;
    logic              emit;
    logic [DW-1:0]     masked_data;

    tsplit_be_gen u_be_gen (
        .off  (off),
        .len  (len),
        .mask (mask),
        .last (last)
    );

    always_comb begin
        state_d = state;
        capture = 1'b0;
        emit    = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_fifo_ne) begin
                    capture = 1'b1;
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                if (!out_fifo_full) begin
                    emit = 1'b1;
                    if (last)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        masked_data = '0;
        for (int i = 0; i < NLANES; i++)
            masked_data[8*i +: 8] = mask[i] ? hold[8*i +: 8] : 8'h00;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            hold             <= '0;
            off              <= '0;
            len              <= '0;
            pkt_fifo_re      <= 1'b0;
            out_fifo_we      <= 1'b0;
            out_fifo_wr_data <= '0;
            out_fifo_wr_be   <= '0;
            piece_cnt        <= '0;
        end else begin
            pkt_fifo_re <= capture;
            out_fifo_we <= emit;
            if (capture) begin
                hold <= pkt_fifo_rd_data;
                len  <= sanitise_len(cfg_piece_len);
                off  <= '0;
            end
            if (emit) begin
                out_fifo_wr_be   <= mask;
                out_fifo_wr_data <= masked_data;
                piece_cnt        <= piece_cnt + 32'd1;
                // Not the last piece, so off+len is still below NLANES and fits in LW bits.
                if (!last)
                    off <= off + len;
            end
        end
    end

endmodule

// File: tb/tb_tsplit.sv
// Bench for tsplit: packet FIFO model, piece scoreboard, merge-stage model and directed
// plus random scenarios.
module tb_tsplit;

    logic        clk;
    logic        reset_l;
    logic [3:0]  cfg_piece_len;
    logic [63:0] pkt_fifo_rd_data;
    logic        pkt_fifo_ne;
    logic        pkt_fifo_re;
    logic [63:0] out_fifo_wr_data;
    logic [7:0]  out_fifo_wr_be;
    logic        out_fifo_we;
    logic        out_fifo_full;
    logic [31:0] piece_cnt;

    tsplit dut (
        .clk              (clk),
        .reset_l          (reset_l),
        .cfg_piece_len    (cfg_piece_len),
        .pkt_fifo_rd_data (pkt_fifo_rd_data),
        .pkt_fifo_ne      (pkt_fifo_ne),
        .pkt_fifo_re      (pkt_fifo_re),
        .out_fifo_wr_data (out_fifo_wr_data),
        .out_fifo_wr_be   (out_fifo_wr_be),
        .out_fifo_we      (out_fifo_we),
        .out_fifo_full    (out_fifo_full),
        .piece_cnt        (piece_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [63:0] pkt_q[$];
    logic [71:0] exp_q[$];
    logic [71:0] got_q[$];
    logic [63:0] word_exp_q[$];
    logic [63:0] merge_acc;
    logic [31:0] cnt_model;
    logic        want_we;
    int          vectors;
    int          miscompares;
    int          re_cnt;
    int          merged_words;

    task automatic drive_pkt();
        pkt_fifo_ne      = (pkt_q.size() != 0);
        pkt_fifo_rd_data = (pkt_q.size() != 0) ? pkt_q[0] : 64'h0;
    endtask

    // Expected pieces of one word: consecutive runs of L lanes from lane 0 upward.
    task automatic push_expected(input logic [63:0] w, input logic [3:0] cfg);
        int l;
        l = (cfg == 4'd0 || cfg > 4'd8) ? 8 : int'(cfg);
        for (int start = 0; start < 8; start += l) begin
            logic [7:0]  be;
            logic [63:0] d;
            be = '0;
            d  = '0;
            for (int b = start; b < start + l && b < 8; b++) begin
                be[b]        = 1'b1;
                d[8*b +: 8]  = w[8*b +: 8];
            end
            exp_q.push_back({be, d});
        end
    endtask

    // One clock: inputs are applied at the negedge, outputs observed at the next negedge.
    task automatic tick();
        logic        full_e;
        logic [3:0]  cfg_e;
        logic [71:0] e;
        logic [63:0] w;
        full_e = out_fifo_full;
        cfg_e  = cfg_piece_len;
        @(posedge clk);
        @(negedge clk);
        if (full_e) begin
            vectors++;
            if (out_fifo_we !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_we: got %b want 0", out_fifo_we);
            end
        end else if (want_we) begin
            want_we = 1'b0;
            vectors++;
            if (out_fifo_we !== 1'b1) begin
                miscompares++;
                $display("FAIL first_piece_latency: we got %b want 1", out_fifo_we);
            end
        end
        if (pkt_fifo_re === 1'b1) begin
            re_cnt++;
            vectors++;
            if (pkt_q.size() == 0 || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL pop_timing: fifo_words %0d pending_pieces %0d want >0 and 0",
                         pkt_q.size(), exp_q.size());
            end else begin
                w = pkt_q.pop_front();
                word_exp_q.push_back(w);
                push_expected(w, cfg_e);
                want_we = 1'b1;
            end
        end
        if (out_fifo_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_piece: got be %h data %h want none",
                         out_fifo_wr_be, out_fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_fifo_wr_be, out_fifo_wr_data} !== e) begin
                    miscompares++;
                    $display("FAIL piece: got be %h data %h want be %h data %h",
                             out_fifo_wr_be, out_fifo_wr_data, e[71:64], e[63:0]);
                end
            end
            got_q.push_back({out_fifo_wr_be, out_fifo_wr_data});
            cnt_model++;
            for (int b = 0; b < 8; b++)
                if (out_fifo_wr_be[b]) merge_acc[8*b +: 8] = out_fifo_wr_data[8*b +: 8];
            if (out_fifo_wr_be[7]) begin
                vectors++;
                if (word_exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL merge_commit: got word %h want none", merge_acc);
                end else begin
                    w = word_exp_q.pop_front();
                    if (merge_acc !== w) begin
                        miscompares++;
                        $display("FAIL merge_word: got %h want %h", merge_acc, w);
                    end
                end
                merged_words++;
                merge_acc = '0;
            end
        end
        vectors++;
        if (piece_cnt !== cnt_model) begin
            miscompares++;
            $display("FAIL piece_cnt: got %0d want %0d", piece_cnt, cnt_model);
        end
        drive_pkt();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pkt_q.size() != 0 || exp_q.size() != 0 || want_we) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (pkt_q.size() != 0 || exp_q.size() != 0 || want_we) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d words %0d pieces outstanding want 0 0",
                     pkt_q.size(), exp_q.size());
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors += 5;
        if (pkt_fifo_re !== 1'b0) begin miscompares++; $display("FAIL reset_re: got %b want 0", pkt_fifo_re); end
        if (out_fifo_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", out_fifo_we); end
        if (out_fifo_wr_data !== 64'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", out_fifo_wr_data); end
        if (out_fifo_wr_be !== 8'h0) begin miscompares++; $display("FAIL reset_be: got %h want 0", out_fifo_wr_be); end
        if (piece_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", piece_cnt); end
        reset_l = 1'b1;
    endtask

    task automatic test_len8();
        cfg_piece_len = 4'd8;
        got_q.delete();
        re_cnt = 0;
        pkt_q.push_back(64'h0706050403020100);
        drive_pkt();
        drain(50);
        vectors += 3;
        if (got_q.size() != 1 || got_q[0] !== {8'hFF, 64'h0706050403020100}) begin
            miscompares++;
            $display("FAIL len8_piece: got %0d pieces first %h want 1 piece ff0706050403020100",
                     got_q.size(), (got_q.size() != 0) ? got_q[0] : 72'h0);
        end
        if (re_cnt != 1) begin miscompares++; $display("FAIL len8_re_pulses: got %0d want 1", re_cnt); end
        if (piece_cnt !== 32'd1) begin miscompares++; $display("FAIL len8_cnt: got %0d want 1", piece_cnt); end
    endtask

    task automatic test_len3();
        logic [71:0] want[3];
        want[0] = {8'h07, 64'h0000000000332211};
        want[1] = {8'h38, 64'h0000665544000000};
        want[2] = {8'hC0, 64'h8877000000000000};
        cfg_piece_len = 4'd3;
        got_q.delete();
        pkt_q.push_back(64'h8877665544332211);
        drive_pkt();
        drain(50);
        vectors++;
        if (got_q.size() != 3) begin
            miscompares++;
            $display("FAIL len3_count: got %0d want 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (got_q[i] !== want[i]) begin
                    miscompares++;
                    $display("FAIL len3_piece%0d: got %h want %h", i, got_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int n;
        logic [7:0] want_be;
        cfg_piece_len = 4'd1;
        got_q.delete();
        pkt_q.push_back({$urandom, $urandom});
        drive_pkt();
        n = 0;
        while (got_q.size() < 2 && n < 20) begin tick(); n++; end
        out_fifo_full = 1'b1;
        repeat (3) tick();
        out_fifo_full = 1'b0;
        drain(50);
        vectors++;
        if (got_q.size() != 8) begin
            miscompares++;
            $display("FAIL stall_count: got %0d want 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                want_be = 8'h01 << i;
                vectors++;
                if (got_q[i][71:64] !== want_be) begin
                    miscompares++;
                    $display("FAIL stall_order%0d: got be %h want %h", i, got_q[i][71:64], want_be);
                end
            end
        end
    endtask

    task automatic test_cfg_change();
        int n;
        logic [7:0] want_be[6];
        logic [3:0] odd_cfg[2];
        want_be[0] = 8'h03; want_be[1] = 8'h0C; want_be[2] = 8'h30;
        want_be[3] = 8'hC0; want_be[4] = 8'h0F; want_be[5] = 8'hF0;
        cfg_piece_len = 4'd2;
        got_q.delete();
        pkt_q.push_back({$urandom, $urandom});
        pkt_q.push_back({$urandom, $urandom});
        drive_pkt();
        n = 0;
        while (got_q.size() < 1 && n < 20) begin tick(); n++; end
        cfg_piece_len = 4'd4;
        drain(80);
        vectors++;
        if (got_q.size() != 6) begin
            miscompares++;
            $display("FAIL cfg_change_count: got %0d want 6", got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (got_q[i][71:64] !== want_be[i]) begin
                    miscompares++;
                    $display("FAIL cfg_change_be%0d: got %h want %h", i, got_q[i][71:64], want_be[i]);
                end
            end
        end
        odd_cfg[0] = 4'd0;
        odd_cfg[1] = 4'd9;
        for (int k = 0; k < 2; k++) begin
            cfg_piece_len = odd_cfg[k];
            got_q.delete();
            pkt_q.push_back({$urandom, $urandom});
            drive_pkt();
            drain(50);
            vectors++;
            if (got_q.size() != 1 || got_q[0][71:64] !== 8'hFF) begin
                miscompares++;
                $display("FAIL cfg_%0d_whole_word: got %0d pieces want 1 piece be ff", odd_cfg[k], got_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        cfg_piece_len = 4'd1;
        got_q.delete();
        pkt_q.push_back({$urandom, $urandom});
        pkt_q.push_back({$urandom, $urandom});
        drive_pkt();
        n = 0;
        while (got_q.size() < 3 && n < 20) begin tick(); n++; end
        #2 reset_l = 1'b0;
        #1;
        vectors += 5;
        if (pkt_fifo_re !== 1'b0) begin miscompares++; $display("FAIL midreset_re: got %b want 0", pkt_fifo_re); end
        if (out_fifo_we !== 1'b0) begin miscompares++; $display("FAIL midreset_we: got %b want 0", out_fifo_we); end
        if (out_fifo_wr_data !== 64'h0) begin miscompares++; $display("FAIL midreset_data: got %h want 0", out_fifo_wr_data); end
        if (out_fifo_wr_be !== 8'h0) begin miscompares++; $display("FAIL midreset_be: got %h want 0", out_fifo_wr_be); end
        if (piece_cnt !== 32'h0) begin miscompares++; $display("FAIL midreset_cnt: got %0d want 0", piece_cnt); end
        exp_q.delete();
        word_exp_q.delete();
        merge_acc = '0;
        cnt_model = '0;
        want_we   = 1'b0;
        re_cnt    = 0;
        @(posedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        got_q.delete();
        drain(50);
        vectors += 3;
        if (got_q.size() != 8) begin miscompares++; $display("FAIL midreset_pieces: got %0d want 8", got_q.size()); end
        if (re_cnt != 1) begin miscompares++; $display("FAIL midreset_pops: got %0d want 1", re_cnt); end
        if (piece_cnt !== 32'd8) begin miscompares++; $display("FAIL midreset_cnt_restart: got %0d want 8", piece_cnt); end
    endtask

    task automatic test_loopback();
        int n;
        int sent;
        int start_words;
        n = 0;
        sent = 0;
        start_words = merged_words;
        while ((sent < 1000 || pkt_q.size() != 0 || exp_q.size() != 0 || want_we) && n < 30000) begin
            if (sent < 1000 && pkt_q.size() < 3 && $urandom_range(0, 3) != 0) begin
                pkt_q.push_back({$urandom, $urandom});
                sent++;
                drive_pkt();
            end
            cfg_piece_len = 4'($urandom_range(0, 15));
            out_fifo_full = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        out_fifo_full = 1'b0;
        tick();
        vectors++;
        if (merged_words - start_words != 1000) begin
            miscompares++;
            $display("FAIL loopback_words: got %0d want 1000", merged_words - start_words);
        end
    endtask

    initial begin
        reset_l          = 1'b0;
        cfg_piece_len    = 4'd0;
        pkt_fifo_rd_data = 64'h0;
        pkt_fifo_ne      = 1'b0;
        out_fifo_full    = 1'b0;
        merge_acc        = '0;
        cnt_model        = '0;
        want_we          = 1'b0;
        vectors          = 0;
        miscompares      = 0;
        re_cnt           = 0;
        merged_words     = 0;

        test_reset();
        test_len8();
        test_len3();
        test_stall();
        test_cfg_change();
        test_reset_mid();
        test_loopback();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
